// File: rtl/vote_input_conditioner.sv
// Input conditioner for a three-candidate voting machine: synchronizes and debounces the
// raw A/B/C buttons, discards multi-button presses and emits one vote strobe per press.
module vote_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vote_enable,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    output logic       vote_valid,
    output logic [1:0] vote_sel,
    output logic       vote_reject,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        QUALIFY      = 3'd1,
        ACCEPT       = 3'd2,
        REJECT       = 3'd3,
        LOCKOUT      = 3'd4,
        WAIT_RELEASE = 3'd5
    } state_t;

    state_t          state;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [2:0]      btn_s;
    logic            en_s;
    logic [1:0]      cand;
    logic [2:0]      cand_oh;
    logic [DW-1:0]   cnt;
    logic [LW-1:0]   lcnt;
    logic            btn_single;
    logic [1:0]      btn_idx;

    // Handshake: vote_valid/vote_reject are single-cycle strobes with no ready; the consumer
    // must take vote_sel in the same cycle vote_valid is high.

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {vote_enable, C, B, A};
            sync2 <= sync1;
        end
    end

    assign btn_s   = sync2[2:0];
    assign en_s    = sync2[3];
    assign cand_oh = 3'b001 << cand;

    always_comb begin
        btn_single = (btn_s == 3'b001) || (btn_s == 3'b010) || (btn_s == 3'b100);
        btn_idx    = 2'd0;
        if (btn_s[1]) begin
            btn_idx = 2'd1;
        end else if (btn_s[2]) begin
            btn_idx = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cand        <= 2'd0;
            cnt         <= '0;
            lcnt        <= '0;
            vote_valid  <= 1'b0;
            vote_reject <= 1'b0;
            vote_sel    <= 2'd0;
        end else begin
            vote_valid  <= 1'b0;
            vote_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_s && (btn_s != 3'b000)) begin
                        if (btn_single) begin
                            cand  <= btn_idx;
                            cnt   <= DW'(1);
                            state <= QUALIFY;
                        end else begin
                            vote_reject <= 1'b1;
                            state       <= REJECT;
                        end
                    end
                end
                QUALIFY: begin
                    // Losing enable or the button both count as an abandoned press.
                    if (!en_s || (btn_s == 3'b000)) begin
                        state <= IDLE;
                    end else if (btn_s == cand_oh) begin
                        if (cnt == DB_LAST) begin
                            vote_valid <= 1'b1;
                            vote_sel   <= cand;
                            state      <= ACCEPT;
                        end else begin
                            cnt <= cnt + DW'(1);
                        end
                    end else begin
                        vote_reject <= 1'b1;
                        state       <= REJECT;
                    end
                end
                ACCEPT: begin
                    lcnt  <= '0;
                    state <= LOCKOUT;
                end
                REJECT: begin
                    state <= WAIT_RELEASE;
                end
                LOCKOUT: begin
                    if (lcnt == LK_LAST) begin
                        state <= WAIT_RELEASE;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                WAIT_RELEASE: begin
                    // A button held through lockout must be let go before it can vote again.
                    if (btn_s == 3'b000) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Bench for vote_input_conditioner: directed scenarios plus random button traffic, each
// cycle compared against a timestamp-based model of press qualification and lockout.
module tb_vote_input_conditioner;

    localparam int D = 4;
    localparam int L = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       vote_enable;
    logic       A;
    logic       B;
    logic       C;
    logic       vote_valid;
    logic [1:0] vote_sel;
    logic       vote_reject;
    logic       busy;
    logic [2:0] state_dbg;
    logic [4:0] obs;

    always #5 clk = ~clk;

    vote_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vote_enable(vote_enable),
        .A          (A),
        .B          (B),
        .C          (C),
        .vote_valid (vote_valid),
        .vote_sel   (vote_sel),
        .vote_reject(vote_reject),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    assign obs = {vote_valid, vote_reject, vote_sel, busy};

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;

    // Model: raw inputs reach the decision logic two edges late; a press is a run of D
    // identical one-hot samples; afterwards the machine is deaf until a release edge.
    bit [3:0]   sync_q[$];
    bit         m_qual;
    bit         m_wait;
    int         m_qstart;
    int         m_cand;
    int         m_release_from;
    logic       m_valid;
    logic       m_reject;
    logic [1:0] m_sel;

    int obs_valid_cnt;
    int obs_reject_cnt;
    int last_valid_edge;
    int obs_votes[3];

    task automatic model_reset();
        sync_q   = {4'b0000, 4'b0000};
        m_qual   = 1'b0;
        m_wait   = 1'b0;
        m_valid  = 1'b0;
        m_reject = 1'b0;
        m_sel    = 2'd0;
    endtask

    task automatic model_edge(input bit [3:0] raw);
        bit [3:0] s;
        bit [2:0] bs;
        bit [2:0] oh;
        bit       es;
        int       ones;
        sync_q.push_back(raw);
        s    = sync_q.pop_front();
        bs   = s[2:0];
        es   = s[3];
        ones = $countones(bs);
        oh   = 3'b001 << m_cand;
        m_valid  = 1'b0;
        m_reject = 1'b0;
        if (m_wait) begin
            if (edge_no >= m_release_from && bs == 3'b000) m_wait = 1'b0;
        end else if (m_qual) begin
            if (!es || bs == 3'b000) begin
                m_qual = 1'b0;
            end else if (bs == oh) begin
                if (edge_no - m_qstart == D - 1) begin
                    m_valid        = 1'b1;
                    m_sel          = 2'(m_cand);
                    m_qual         = 1'b0;
                    m_wait         = 1'b1;
                    m_release_from = edge_no + L + 2;
                end
            end else begin
                m_reject       = 1'b1;
                m_qual         = 1'b0;
                m_wait         = 1'b1;
                m_release_from = edge_no + 2;
            end
        end else if (es && ones == 1) begin
            m_qual   = 1'b1;
            m_qstart = edge_no;
            m_cand   = bs[0] ? 0 : (bs[1] ? 1 : 2);
        end else if (es && ones > 1) begin
            m_reject       = 1'b1;
            m_wait         = 1'b1;
            m_release_from = edge_no + 2;
        end
    endtask

    function automatic logic [4:0] exp_vec();
        return {m_valid, m_reject, m_sel, (m_qual || m_wait)};
    endfunction

    task automatic clear_tally();
        obs_valid_cnt   = 0;
        obs_reject_cnt  = 0;
        last_valid_edge = -1;
        for (int k = 0; k < 3; k++) obs_votes[k] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        model_edge({vote_enable, C, B, A});
        #1;
        if (vote_valid === 1'b1) begin
            obs_valid_cnt++;
            last_valid_edge = edge_no;
            if (vote_sel != 2'd3) obs_votes[vote_sel]++;
        end
        if (vote_reject === 1'b1) obs_reject_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        vectors++;
        if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_values: got %b want 00000", obs);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single_press();
        int n;
        clear_tally();
        vote_enable = 1'b1;
        n = edge_no + 4;
        for (int i = 0; i < 13 + L + 20; i++) begin
            A = (i >= 3 && i < 13);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
            if (edge_no == n + 2 || edge_no == n + 1) begin
                vectors++;
                if (busy !== (edge_no == n + 2)) begin
                    miscompares++;
                    $display("FAIL single_busy_start edge %0d: got %b", edge_no, busy);
                end
            end
        end
        vectors++;
        if (obs_valid_cnt != 1 || last_valid_edge != n + D + 1 || obs_votes[0] != 1) begin
            miscompares++;
            $display("FAIL single_latency: got %0d strobes at edge %0d, want 1 at edge %0d",
                     obs_valid_cnt, last_valid_edge, n + D + 1);
        end
    endtask

    task automatic test_bounce();
        clear_tally();
        for (int i = 0; i < 20; i++) begin
            B = (i < 3) || (i >= 5 && i < 8);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL bounce_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        vectors++;
        if (obs_valid_cnt != 0 || obs_reject_cnt != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_filter: got valid=%0d reject=%0d busy=%b, want 0 0 0",
                     obs_valid_cnt, obs_reject_cnt, busy);
        end
    endtask

    task automatic test_lockout_hold();
        clear_tally();
        for (int i = 0; i < 2 * L + 10; i++) begin
            C = (i < 2 * L);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
            if (i == 2 * L - 1) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_busy: got %b want 1 while still held", busy);
                end
            end
        end
        vectors++;
        if (obs_votes[2] != 1 || obs_valid_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_one_vote: got C=%0d total=%0d busy=%b, want 1 1 0",
                     obs_votes[2], obs_valid_cnt, busy);
        end
        clear_tally();
        for (int i = 0; i < 70 + L + 20; i++) begin
            C = (i < 10) || (i >= 20 && i < 30) || (i >= 60 && i < 70);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL repress_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        vectors++;
        if (obs_votes[2] != 2 || obs_valid_cnt != 2) begin
            miscompares++;
            $display("FAIL repress_count: got C=%0d total=%0d, want 2 2", obs_votes[2], obs_valid_cnt);
        end
    endtask

    task automatic test_simultaneous();
        clear_tally();
        for (int i = 0; i < 20; i++) begin
            A = (i < 10);
            C = (i < 10);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL simul_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        vectors++;
        if (obs_reject_cnt != 1 || obs_valid_cnt != 0 || vote_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL simul_reject: got reject=%0d valid=%0d sel=%0d, want 1 0 2",
                     obs_reject_cnt, obs_valid_cnt, vote_sel);
        end
    endtask

    task automatic test_enable_gating();
        bit seen_busy;
        clear_tally();
        seen_busy   = 1'b0;
        vote_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            A = (i >= 3 && i < 13);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_off_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        for (int i = 0; i < 30; i++) begin
            vote_enable = (i < 6);
            B = (i >= 5 && i < 15);
            step();
            if (busy === 1'b1) seen_busy = 1'b1;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL en_drop_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        vectors++;
        if (obs_valid_cnt != 0 || obs_reject_cnt != 0 || !seen_busy || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_gating: got valid=%0d reject=%0d seen_busy=%b busy=%b, want 0 0 1 0",
                     obs_valid_cnt, obs_reject_cnt, seen_busy, busy);
        end
    endtask

    task automatic test_async_reset();
        int n;
        clear_tally();
        vote_enable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            A = (i >= 2 && i < 12);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL prereset_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        vectors++;
        if (obs_valid_cnt != 1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL prereset_lockout: got valid=%0d busy=%b, want 1 1", obs_valid_cnt, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== 5'b00000) begin
            miscompares++;
            $display("FAIL async_clear: got %b want 00000", obs);
        end
        A = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        clear_tally();
        n = edge_no + 4;
        for (int i = 0; i < 13 + L + 20; i++) begin
            A = (i >= 3 && i < 13);
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL postreset_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
        vectors++;
        if (obs_valid_cnt != 1 || last_valid_edge != n + D + 1) begin
            miscompares++;
            $display("FAIL postreset_latency: got %0d strobes at edge %0d, want 1 at edge %0d",
                     obs_valid_cnt, last_valid_edge, n + D + 1);
        end
    endtask

    task automatic test_sequence();
        bit [2:0] who;
        clear_tally();
        for (int p = 0; p < 9; p++) begin
            who = (p < 5) ? 3'b001 : ((p < 8) ? 3'b010 : 3'b100);
            for (int i = 0; i < 10 + L + 20; i++) begin
                {C, B, A} = (i < 10) ? who : 3'b000;
                step();
                vectors++;
                if (obs !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL seq_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
                end
            end
        end
        vectors++;
        if (obs_votes[0] != 5 || obs_votes[1] != 3 || obs_votes[2] != 1) begin
            miscompares++;
            $display("FAIL seq_counts: got A=%0d B=%0d C=%0d, want 5 3 1",
                     obs_votes[0], obs_votes[1], obs_votes[2]);
        end
    endtask

    task automatic test_random();
        int       seg_left;
        int       r;
        bit [2:0] b;
        seg_left = 0;
        b        = 3'b000;
        clear_tally();
        for (int i = 0; i < 1500; i++) begin
            if (seg_left == 0) begin
                seg_left = $urandom_range(1, 14);
                r = $urandom_range(0, 7);
                if (r < 4)      b = 3'b001 << $urandom_range(0, 2);
                else if (r < 6) b = 3'b000;
                else            b = 3'($urandom_range(0, 7));
                vote_enable = ($urandom_range(0, 7) != 0);
            end
            seg_left--;
            {C, B, A} = b;
            step();
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_cycle edge %0d: got %b want %b", edge_no, obs, exp_vec());
            end
        end
    endtask

    initial begin
        A = 1'b0;
        B = 1'b0;
        C = 1'b0;
        vote_enable = 1'b0;
        model_reset();
        clear_tally();
        test_reset();
        test_single_press();
        test_bounce();
        test_lockout_hold();
        test_simultaneous();
        test_enable_gating();
        test_async_reset();
        test_sequence();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
